// File: rtl/tick_pkg.sv
// Shared definitions for the market-data tick path: frame layout, magic/type bytes,
// side encoding (also used by the order-book stage) and the decoder FSM states.
package tick_pkg;

    localparam int unsigned MSG_LEN   = 20;
    localparam logic [7:0]  MAGIC     = 8'hA5;
    localparam logic [7:0]  MSG_TICK  = 8'h01;

    localparam logic [4:0]  OFF_TYPE  = 5'd1;
    localparam logic [4:0]  OFF_SIDE  = 5'd2;
    localparam logic [4:0]  OFF_PRICE = 5'd3;
    localparam logic [4:0]  OFF_QTY   = 5'd11;
    localparam logic [4:0]  OFF_CHK   = 5'(MSG_LEN - 1);

    typedef enum logic {
        SIDE_BUY  = 1'b0,
        SIDE_SELL = 1'b1
    } side_e;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StBody,
        StChk,
        StDrain
    } state_e;

    // Only 8'h00 and 8'h01 are legal side bytes on the wire.
    function automatic logic side_byte_ok(input logic [7:0] b);
        return b[7:1] == 7'd0;
    endfunction

endpackage

// File: rtl/tick_xor_acc.sv
// Running XOR of accepted frame bytes; clear has priority over enable.
module tick_xor_acc (
    input  logic       clk,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);

    always_ff @(posedge clk) begin
        if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/udp_tick_decoder.sv
// Parses one 20-byte market-data payload into a price/qty/side tick; drops and counts bad frames.
// Define UDP_TICK_CHECKSUM_EN to verify the trailing XOR checksum byte.
module udp_tick_decoder
    import tick_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [63:0] tick_price,
    output logic [63:0] tick_qty,
    output logic        tick_side,
    output logic        tick_valid,
    output logic        drop_pulse,
    output logic [15:0] err_count
);

    state_e      state;
    logic [4:0]  idx;
    logic [63:0] price_stage;
    logic [63:0] qty_stage;
    side_e       side_stage;
    logic        accept;
    logic        chk_ok;
    logic        byte_err;

    assign in_ready = rst_n;
    assign accept   = in_valid & in_ready;

`ifdef UDP_TICK_CHECKSUM_EN
    logic [7:0] xor_val;

    // Every accepted in_last returns the FSM to IDLE, so that is where the sum is cleared.
    tick_xor_acc u_xor_acc (
        .clk   (clk),
        .clear (~rst_n | (accept & in_last)),
        .en    (accept & (state != StChk) & (state != StDrain)),
        .din   (in_data),
        .acc   (xor_val)
    );

    assign chk_ok = (in_data == xor_val);
`else
    assign chk_ok = 1'b1;
`endif

    always_comb begin
        byte_err = 1'b0;
        unique case (state)
            StIdle:  byte_err = (in_data != MAGIC) | in_last;
            StHdr: begin
                if (idx == OFF_TYPE) begin
                    // A foreign message type is discarded silently, whatever its length.
                    byte_err = (in_data == MSG_TICK) & in_last;
                end else begin
                    byte_err = ~side_byte_ok(in_data) | in_last;
                end
            end
            StBody:  byte_err = in_last;
            StChk:   byte_err = ~chk_ok | ~in_last;
            default: byte_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= StIdle;
            idx         <= '0;
            price_stage <= '0;
            qty_stage   <= '0;
            side_stage  <= SIDE_BUY;
            tick_price  <= '0;
            tick_qty    <= '0;
            tick_side   <= 1'b0;
            tick_valid  <= 1'b0;
            drop_pulse  <= 1'b0;
            err_count   <= '0;
        end else begin
            tick_valid <= 1'b0;
            drop_pulse <= 1'b0;
            if (accept) begin
                if (byte_err) begin
                    drop_pulse <= 1'b1;
                    if (err_count != 16'hFFFF) begin
                        err_count <= err_count + 16'd1;
                    end
                    state <= in_last ? StIdle : StDrain;
                    idx   <= '0;
                end else begin
                    unique case (state)
                        StIdle: begin
                            state <= StHdr;
                            idx   <= OFF_TYPE;
                        end
                        StHdr: begin
                            if (idx == OFF_TYPE) begin
                                if (in_data != MSG_TICK) begin
                                    state <= in_last ? StIdle : StDrain;
                                    idx   <= '0;
                                end else begin
                                    idx <= OFF_SIDE;
                                end
                            end else begin
                                side_stage <= in_data[0] ? SIDE_SELL : SIDE_BUY;
                                state      <= StBody;
                                idx        <= OFF_PRICE;
                            end
                        end
                        StBody: begin
                            if (idx < OFF_QTY) begin
                                price_stage <= {price_stage[55:0], in_data};
                            end else begin
                                qty_stage <= {qty_stage[55:0], in_data};
                            end
                            idx <= idx + 5'd1;
                            if (idx == OFF_CHK - 5'd1) begin
                                state <= StChk;
                            end
                        end
                        StChk: begin
                            tick_price <= price_stage;
                            tick_qty   <= qty_stage;
                            tick_side  <= side_stage;
                            tick_valid <= 1'b1;
                            state      <= StIdle;
                            idx        <= '0;
                        end
                        StDrain: begin
                            if (in_last) begin
                                state <= StIdle;
                                idx   <= '0;
                            end
                        end
                        default: begin
                            state <= StIdle;
                            idx   <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_udp_tick_decoder.sv
// Bench for udp_tick_decoder: directed scenarios plus randomized frames against a frame-level model.
module tb_udp_tick_decoder;

`ifdef UDP_TICK_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [63:0] tick_price;
    logic [63:0] tick_qty;
    logic        tick_side;
    logic        tick_valid;
    logic        drop_pulse;
    logic [15:0] err_count;

    udp_tick_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .tick_price (tick_price),
        .tick_qty   (tick_qty),
        .tick_side  (tick_side),
        .tick_valid (tick_valid),
        .drop_pulse (drop_pulse),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  fq[$];
    logic [63:0] m_price = '0;
    logic [63:0] m_qty = '0;
    logic        m_side = 1'b0;
    logic [15:0] m_err = '0;

    int obs_tick, obs_drop, obs_pulses;
    int exp_tick, exp_drop, exp_pulses;

    // Frame builder: correct checksum unless bad_chk flips one bit of it.
    task automatic build(input logic [7:0] magic, input logic [7:0] typ, input logic [7:0] side,
                         input logic [63:0] price, input logic [63:0] qty, input bit bad_chk);
        logic [7:0] c;
        fq.delete();
        fq.push_back(magic);
        fq.push_back(typ);
        fq.push_back(side);
        for (int i = 7; i >= 0; i--) fq.push_back(price[8*i +: 8]);
        for (int i = 7; i >= 0; i--) fq.push_back(qty[8*i +: 8]);
        c = 8'h00;
        foreach (fq[i]) c = c ^ fq[i];
        if (bad_chk) c = c ^ 8'h40;
        fq.push_back(c);
    endtask

    // Frame-level outcome: which byte index triggers the event, and kind 0 none / 1 tick / 2 drop.
    task automatic predict(output int ev, output int kind);
        int n;
        logic [7:0] x;
        n = fq.size();
        ev = -1;
        kind = 0;
        x = 8'h00;
        for (int i = 0; i < 19 && i < n; i++) x = x ^ fq[i];
        if (fq[0] != 8'hA5 || n == 1) begin ev = 0; kind = 2; end
        else if (fq[1] != 8'h01) begin ev = -1; kind = 0; end
        else if (n == 2) begin ev = 1; kind = 2; end
        else if (fq[2] > 8'h01) begin ev = 2; kind = 2; end
        else if (n < 20) begin ev = n - 1; kind = 2; end
        else if (CHK_EN && fq[19] != x) begin ev = 19; kind = 2; end
        else if (n > 20) begin ev = 19; kind = 2; end
        else begin ev = 19; kind = 1; end
    endtask

    task automatic note(input int cyc);
        if (tick_valid === 1'b1) begin
            obs_pulses++;
            if (obs_tick < 0) obs_tick = cyc;
        end
        if (drop_pulse === 1'b1) begin
            obs_pulses++;
            if (obs_drop < 0) obs_drop = cyc;
        end
    endtask

    // Drives fq as one payload; records observed pulse cycles and the model's expectation.
    task automatic send_frame(input bit rnd_gaps, input int gap_at, input int gap_len);
        int ev, kind, cyc, g, n;
        predict(ev, kind);
        n = fq.size();
        obs_tick = -1; obs_drop = -1; obs_pulses = 0;
        exp_tick = -1; exp_drop = -1; exp_pulses = (kind != 0) ? 1 : 0;
        cyc = 0;
        for (int k = 0; k < n; k++) begin
            g = (k == gap_at) ? gap_len : 0;
            if (rnd_gaps && $urandom_range(0, 3) == 0) g = $urandom_range(1, 3);
            for (int j = 0; j < g; j++) begin
                in_valid = 1'b0;
                in_last = 1'b0;
                @(posedge clk); #1;
                note(cyc);
                cyc++;
            end
            in_valid = 1'b1;
            in_data = fq[k];
            in_last = (k == n - 1);
            @(posedge clk); #1;
            if (k == ev) begin
                if (kind == 1) exp_tick = cyc;
                else exp_drop = cyc;
            end
            note(cyc);
            cyc++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = 8'h00;
        @(posedge clk); #1;
        note(cyc);
        if (kind == 1) begin
            m_side = fq[2][0];
            for (int i = 0; i < 8; i++) begin
                m_price = {m_price[55:0], fq[3 + i]};
                m_qty = {m_qty[55:0], fq[11 + i]};
            end
        end else if (kind == 2 && m_err != 16'hFFFF) begin
            m_err = m_err + 16'd1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        checks++;
        if ({tick_price, tick_qty, tick_side, tick_valid, drop_pulse, err_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: price %h qty %h side %b tv %b dp %b err %0d want all 0",
                     tick_price, tick_qty, tick_side, tick_valid, drop_pulse, err_count);
        end
        rst_n = 1'b1;
        m_price = '0; m_qty = '0; m_side = 1'b0; m_err = '0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_valid_buy();
        build(8'hA5, 8'h01, 8'h00, 64'h0000_0000_0001_86A0, 64'h10, 1'b0);
        send_frame(1'b0, -1, 0);
        checks++;
        if (obs_tick !== 19) begin
            errors++; $display("FAIL buy_tick_cycle: got %0d want 19", obs_tick);
        end
        checks++;
        if (obs_pulses !== 1 || obs_drop !== -1) begin
            errors++; $display("FAIL buy_pulses: got %0d drop@%0d want 1 tick only", obs_pulses, obs_drop);
        end
        checks++;
        if (tick_price !== 64'd100000 || tick_qty !== 64'd16 || tick_side !== 1'b0) begin
            errors++;
            $display("FAIL buy_fields: got %0d/%0d/%b want 100000/16/0", tick_price, tick_qty, tick_side);
        end
        checks++;
        if (err_count !== 16'd0) begin
            errors++; $display("FAIL buy_err_count: got %0d want 0", err_count);
        end
    endtask

    task automatic test_stall();
        build(8'hA5, 8'h01, 8'h00, 64'h0000_0000_0001_86A0, 64'h10, 1'b0);
        send_frame(1'b0, 8, 3);
        checks++;
        if (obs_tick !== 22 || obs_pulses !== 1) begin
            errors++; $display("FAIL stall_tick_cycle: got %0d (%0d pulses) want 22 (1)", obs_tick, obs_pulses);
        end
        checks++;
        if (tick_price !== 64'd100000 || tick_qty !== 64'd16 || tick_side !== 1'b0) begin
            errors++;
            $display("FAIL stall_fields: got %0d/%0d/%b want 100000/16/0", tick_price, tick_qty, tick_side);
        end
    endtask

    task automatic test_bad_magic();
        build(8'h5A, 8'h01, 8'h01, 64'h55, 64'h66, 1'b0);
        send_frame(1'b0, -1, 0);
        checks++;
        if (obs_drop !== 0 || obs_pulses !== 1 || obs_tick !== -1) begin
            errors++;
            $display("FAIL magic_drop: drop@%0d tick@%0d pulses %0d want drop@0 only", obs_drop, obs_tick, obs_pulses);
        end
        checks++;
        if (err_count !== m_err || tick_price !== 64'd100000) begin
            errors++; $display("FAIL magic_state: err %0d price %0d want %0d 100000", err_count, tick_price, m_err);
        end
        build(8'hA5, 8'h01, 8'h01, 64'hDEAD_BEEF_0000_0001, 64'd777, 1'b0);
        send_frame(1'b0, -1, 0);
        checks++;
        if (obs_tick !== 19 || tick_price !== 64'hDEAD_BEEF_0000_0001 || tick_qty !== 64'd777
            || tick_side !== 1'b1) begin
            errors++;
            $display("FAIL magic_recover: tick@%0d %h/%0d/%b want 19 deadbeef00000001/777/1",
                     obs_tick, tick_price, tick_qty, tick_side);
        end
    endtask

    task automatic test_short_long();
        logic [15:0] base;
        int drops;
        base = m_err;
        build(8'hA5, 8'h01, 8'h00, 64'h1234, 64'h5678, 1'b0);
        fq = fq[0:12];
        send_frame(1'b0, -1, 0);
        drops = obs_pulses;
        checks++;
        if (obs_drop !== 12) begin
            errors++; $display("FAIL short_drop_cycle: got %0d want 12", obs_drop);
        end
        build(8'hA5, 8'h01, 8'h00, 64'h1234, 64'h5678, 1'b0);
        for (int i = 0; i < 5; i++) fq.push_back(8'(i + 3));
        send_frame(1'b0, -1, 0);
        drops += obs_pulses;
        checks++;
        if (obs_drop !== 19 || obs_tick !== -1) begin
            errors++; $display("FAIL long_drop_cycle: got %0d tick@%0d want 19 no tick", obs_drop, obs_tick);
        end
        checks++;
        if (err_count !== base + 16'd2 || drops !== 2) begin
            errors++; $display("FAIL short_long_count: err %0d pulses %0d want %0d 2", err_count, drops, base + 16'd2);
        end
        checks++;
        if (tick_price !== m_price || tick_qty !== m_qty || tick_side !== m_side) begin
            errors++; $display("FAIL short_long_hold: got %h/%h/%b want %h/%h/%b",
                               tick_price, tick_qty, tick_side, m_price, m_qty, m_side);
        end
    endtask

    task automatic test_type_discard();
        build(8'hA5, 8'h02, 8'h00, 64'h9, 64'h9, 1'b0);
        send_frame(1'b0, -1, 0);
        checks++;
        if (obs_pulses !== 0 || err_count !== m_err) begin
            errors++; $display("FAIL type_discard: pulses %0d err %0d want 0 %0d", obs_pulses, err_count, m_err);
        end
        fq.delete();
        fq.push_back(8'hA5);
        send_frame(1'b0, -1, 0);
        checks++;
        if (obs_drop !== 0 || err_count !== m_err) begin
            errors++; $display("FAIL single_byte: drop@%0d err %0d want 0 %0d", obs_drop, err_count, m_err);
        end
    endtask

    task automatic test_checksum();
        build(8'hA5, 8'h01, 8'h01, 64'h4242, 64'h99, 1'b1);
        send_frame(1'b0, -1, 0);
        checks++;
        if ((obs_drop == 19) !== CHK_EN || (obs_tick == 19) !== !CHK_EN || obs_pulses !== 1) begin
            errors++; $display("FAIL bad_checksum: drop@%0d tick@%0d want checking=%b",
                               obs_drop, obs_tick, CHK_EN);
        end
        checks++;
        if (err_count !== m_err || tick_price !== m_price) begin
            errors++; $display("FAIL checksum_state: err %0d price %h want %0d %h", err_count, tick_price, m_err, m_price);
        end
    endtask

    task automatic test_reset_mid_frame();
        build(8'hA5, 8'h01, 8'h00, 64'h1111_2222_3333_4444, 64'h5, 1'b0);
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1; in_data = fq[k]; in_last = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || err_count !== 16'd0 || tick_price !== 64'd0) begin
            errors++; $display("FAIL midreset_state: rdy %b err %0d price %h want 0 0 0", in_ready, err_count, tick_price);
        end
        rst_n = 1'b1;
        m_price = '0; m_qty = '0; m_side = 1'b0; m_err = '0;
        fq = fq[7:$];
        send_frame(1'b0, -1, 0);
        checks++;
        if (obs_drop !== 0 || obs_pulses !== 1 || err_count !== 16'd1) begin
            errors++; $display("FAIL midreset_leftover: drop@%0d pulses %0d err %0d want 0 1 1",
                               obs_drop, obs_pulses, err_count);
        end
    endtask

    task automatic test_random();
        logic [7:0]  mg, ty, sd;
        logic [63:0] pr, qt;
        bit          bc;
        int          mode;
        for (int f = 0; f < 60; f++) begin
            mode = $urandom_range(0, 7);
            mg = 8'hA5; ty = 8'h01; sd = 8'($urandom_range(0, 1));
            pr = {$urandom, $urandom}; qt = {$urandom, $urandom}; bc = 1'b0;
            if (mode == 2) mg = (8'($urandom) == 8'hA5) ? 8'h00 : 8'($urandom);
            if (mode == 5) sd = 8'($urandom_range(2, 255));
            if (mode == 6) ty = 8'($urandom_range(2, 255));
            if (mode == 7) bc = 1'b1;
            build(mg, ty, sd, pr, qt, bc);
            if (mode == 3) fq = fq[0:$urandom_range(0, 18)];
            if (mode == 4) repeat ($urandom_range(1, 6)) fq.push_back(8'($urandom));
            send_frame(1'b1, -1, 0);
            checks++;
            if (obs_tick !== exp_tick || obs_drop !== exp_drop || obs_pulses !== exp_pulses) begin
                errors++; $display("FAIL rand_pulses[%0d]: tick@%0d drop@%0d n%0d want %0d %0d n%0d",
                                   f, obs_tick, obs_drop, obs_pulses, exp_tick, exp_drop, exp_pulses);
            end
            checks++;
            if (tick_price !== m_price || tick_qty !== m_qty || tick_side !== m_side
                || err_count !== m_err) begin
                errors++; $display("FAIL rand_fields[%0d]: %h/%h/%b/%0d want %h/%h/%b/%0d", f,
                                   tick_price, tick_qty, tick_side, err_count, m_price, m_qty, m_side, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_valid_buy();
        test_stall();
        test_bad_magic();
        test_short_long();
        test_type_discard();
        test_checksum();
        test_random();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_tick_decoder.md
# udp_tick_decoder

- Parses the byte stream of one market-data UDP payload into a single tick of price, quantity and side.
- Sits directly upstream of the order-book reconstruction stage and drives its tick_price / tick_qty / tick_side / valid_in inputs.
- Malformed frames are dropped and counted.
- Accepts one byte per cycle and never back-pressures after reset.

## Interface
- MAGIC, 8'hA5, required value of frame byte 0
- MSG_TICK, 8'h01, message type (byte 1) that carries a tick
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- in_data  in  8  payload byte
- in_valid  in  1  in_data valid this cycle
- in_last  in  1  in_data is the final byte of the UDP payload
- in_ready  out  1  0 while rst_n low, 1 otherwise
- tick_price  out  64  decoded price, unsigned, big-endian on the wire
- tick_qty  out  64  decoded quantity, unsigned, big-endian on the wire
- tick_side  out  1  0 = buy, 1 = sell
- tick_valid  out  1  one-cycle pulse: tick fields are new
- drop_pulse  out  1  one-cycle pulse per frame dropped for an error
- err_count  out  16  dropped-frame count, saturates at 16'hFFFF

## Operation
- A byte is accepted on any cycle with in_valid & in_ready. Cycles with in_valid low stall the parse; there is no timeout.
- Frame layout, 20 bytes (MSG_LEN), byte index from 0:
  - 0: magic
  - 1: type
  - 2: side (8'h00 = buy, 8'h01 = sell)
  - 3–10: price, MSB first
  - 11–18: quantity, MSB first
  - 19: checksum, the XOR of bytes 0–18
- FSM states: IDLE, HDR, BODY, CHK, DRAIN.
  - IDLE: accepts byte 0.
    - Byte 0 ≠ MAGIC is an error.
    - Otherwise go to HDR.
  - HDR: accepts bytes 1–2.
    - Type ≠ MSG_TICK is a silent discard: go to DRAIN, no error, no count.
    - Side byte other than 00/01 is an error.
  - BODY: accepts bytes 3–18 and shifts price and qty into staging registers.
  - CHK: accepts byte 19.
    - Checksum mismatch is an error.
    - If in_last is also set: commit the staged fields, pulse tick_valid, go to IDLE.
    - If in_last is clear (long frame): error, go to DRAIN.
  - DRAIN: discards bytes until in_last, then goes to IDLE.
- Errors:
  - in_last on any byte before index 19 (short frame) is an error; go directly to IDLE.
  - Any error pulses drop_pulse, increments err_count by 1 (saturating), and leaves the tick outputs unchanged.
  - After an error, go to DRAIN unless the erroring byte carried in_last, in which case go to IDLE.
  - Exactly one drop_pulse per frame, even when several checks fail.
- Byte index counter is 5 bits and resets to 0 on every return to IDLE.
- tick_price, tick_qty and tick_side hold their last committed values until the next commit.
- The running XOR accumulator clears on entering IDLE.

## Timing
- Reset values:
  - in_ready = 0 during reset
  - tick_price = 0, tick_qty = 0, tick_side = 0
  - tick_valid = 0, drop_pulse = 0, err_count = 0
  - FSM in IDLE
- Latency: tick_valid rises in the cycle after byte 19 is accepted. The minimum spacing between tick_valid pulses is 20 cycles.
- drop_pulse rises in the cycle after the erroring byte is accepted.
- Reset mid-frame:
  - The partial frame is discarded with no count.
  - The next accepted byte is treated as byte 0. Leftover bytes of the old frame normally fail the magic check and are counted once.
- A single-byte frame (in_last on byte 0 with the correct magic) counts as a short-frame error.

## Configuration
- UDP_TICK_CHECKSUM_EN defined: byte 19 is verified as described under Operation.
- Not defined:
  - Byte 19 is consumed but ignored, and the XOR accumulator is not built.
  - Frame length and in_last rules are unchanged.

## Structure
- Shared package tick_pkg holds:
  - MSG_LEN = 20
  - byte offsets: OFF_TYPE = 1, OFF_SIDE = 2, OFF_PRICE = 3, OFF_QTY = 11, OFF_CHK = 19
  - side encodings SIDE_BUY / SIDE_SELL
  - the FSM state enum
  - The order-book stage imports the same side encoding.
- One sub-module, tick_xor_acc: clear / enable / byte in, 8-bit running XOR out. Instantiated only under UDP_TICK_CHECKSUM_EN.

## Test plan
- Valid buy frame: price 0x0000_0000_0001_86A0, qty 0x10, correct checksum, in_last on byte 19 → one tick_valid pulse with tick_price = 100000, tick_qty = 16, tick_side = 0; err_count stays 0.
- Same frame with in_valid deasserted for 3 cycles between bytes 7 and 8 → identical outputs, tick_valid delayed by exactly 3 cycles.
- Frame with byte 0 = 8'h5A, 20 bytes long → one drop_pulse, err_count = 1, no tick_valid. The next good frame decodes normally.
- Short frame (in_last on byte 12), then a long frame (25 bytes) → err_count = 2, two drop_pulse pulses, tick outputs unchanged.
- Type byte 8'h02, well-formed 20-byte frame → no tick_valid, no drop_pulse, err_count unchanged.
- Corrupted checksum: with UDP_TICK_CHECKSUM_EN, drop_pulse and err_count = 1. Without it, tick_valid pulses.
